// File: rtl/pipeline.sv
// Fixed-latency delay line of DEPTH register stages with a global stall that freezes every stage.
// Define PIPELINE_ASSERT_EN to compile in simulation-only parameter, X/Z and stall-hold checks.
module pipeline #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_out
);

    logic [DEPTH-1:0][XLEN-1:0] stage_q;
    logic [DEPTH-1:0][XLEN-1:0] stage_d;

    // Advance every stage one step unless stalled; stage 0 is the only one that samples data_in.
    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            stage_d[0] = data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Reset takes priority over stall so a frozen pipeline can still be flushed.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_out = stage_q[DEPTH-1];

`ifdef PIPELINE_ASSERT_EN
    if (DEPTH < 1 || XLEN < 1) begin : g_badParams
        $error("pipeline: DEPTH (%0d) and XLEN (%0d) must both be at least 1", DEPTH, XLEN);
    end

    dataInKnown: assert property (@(posedge clock) (!reset && !stall) |-> !$isunknown(data_in))
        else $error("pipeline: data_in contains X/Z on a capturing edge");

    stallHolds: assert property (@(posedge clock) (!reset && stall) |=> $stable(data_out))
        else $error("pipeline: data_out changed on a stalled edge");
`else
`endif

endmodule

// File: tb/tb_pipeline.sv
// Scoreboard bench for pipeline (XLEN=32, DEPTH=4): the driver queues the hand-derived output
// expected after each edge, and an independent monitor pops and compares on the falling edge.
module tb_pipeline;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [XLEN-1:0] value;
        string           name;
    } expEntry_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            stall;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] data_out;

    expEntry_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] words [100];

    pipeline #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    // Drive one edge's inputs and queue the data_out expected once that edge has happened.
    task automatic applyStimulus(input logic rst, input logic stl, input logic [XLEN-1:0] din,
                                 input logic [XLEN-1:0] expVal, input string name);
        expEntry_t e;
        reset   = rst;
        stall   = stl;
        data_in = din;
        @(posedge clock);
        e.value = expVal;
        e.name  = name;
        expQ.push_back(e);
        @(negedge clock);
    endtask

    task automatic checkOutput(input logic [XLEN-1:0] expVal, input string name);
        compared++;
        if (data_out !== expVal) begin
            mismatched++;
            $display("[TB] FAIL %s: data_out=%h expected=%h", name, data_out, expVal);
        end
    endtask

    // Monitor: one expectation is retired per edge, sampled half a cycle after the edge.
    initial begin
        expEntry_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e.value, e.name);
            end
        end
    end

    // Watchdog so a broken bench can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [XLEN-1:0] expVal;

        reset   = 1'b1;
        stall   = 1'b0;
        data_in = '0;

        // Power-up reset.
        applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, "resetInit0");
        applyStimulus(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, "resetInit1");

        // Directed stream: first word emerges after the 4th capture edge.
        applyStimulus(1'b0, 1'b0, 32'h1111_1111, 32'h0,         "dirEdge1");
        applyStimulus(1'b0, 1'b0, 32'h2222_2222, 32'h0,         "dirEdge2");
        applyStimulus(1'b0, 1'b0, 32'h3333_3333, 32'h0,         "dirEdge3");
        applyStimulus(1'b0, 1'b0, 32'h4444_4444, 32'h1111_1111, "dirEdge4");
        applyStimulus(1'b0, 1'b0, 32'h5555_5555, 32'h2222_2222, "dirEdge5");
        applyStimulus(1'b0, 1'b0, 32'h6666_6666, 32'h3333_3333, "dirEdge6");
        applyStimulus(1'b0, 1'b0, 32'h7777_7777, 32'h4444_4444, "dirEdge7");
        applyStimulus(1'b0, 1'b0, 32'h8888_8888, 32'h5555_5555, "dirEdge8");

        // Reset with a full pipeline, then the next three edges must still show zero.
        applyStimulus(1'b1, 1'b0, 32'h9999_9999, 32'h0,  "rstFlush");
        applyStimulus(1'b0, 1'b0, 32'h0000_00B0, 32'h0,  "rstAfter1");
        applyStimulus(1'b0, 1'b0, 32'h0000_00B1, 32'h0,  "rstAfter2");
        applyStimulus(1'b0, 1'b0, 32'h0000_00B2, 32'h0,  "rstAfter3");
        applyStimulus(1'b0, 1'b0, 32'h0000_00B3, 32'hB0, "rstAfter4");

        // Load A0..A3, stall ten edges with junk on data_in, then release.
        applyStimulus(1'b0, 1'b0, 32'h0000_00A0, 32'hB1, "loadA0");
        applyStimulus(1'b0, 1'b0, 32'h0000_00A1, 32'hB2, "loadA1");
        applyStimulus(1'b0, 1'b0, 32'h0000_00A2, 32'hB3, "loadA2");
        applyStimulus(1'b0, 1'b0, 32'h0000_00A3, 32'hA0, "loadA3");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, 32'hA0, $sformatf("stallHold%0d", i));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'hA1, "stallRel1");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'hA2, "stallRel2");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'hA3, "stallRel3");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0,  "stallRel4");

        // Twenty-word stream interrupted by a reset.
        for (int k = 1; k <= 20; k++) begin
            words[k-1] = $urandom;
            expVal = (k >= DEPTH) ? words[k-DEPTH] : '0;
            applyStimulus(1'b0, 1'b0, words[k-1], expVal, $sformatf("streamA%0d", k));
        end
        applyStimulus(1'b1, 1'b0, $urandom, 32'h0, "midStreamReset");

        // 100-word stream with occasional stalls; latency counts only non-stalled edges.
        for (int i = 0; i < 100; i++) words[i] = $urandom;
        n = 0;
        for (int k = 1; n < 100; k++) begin
            if (k % 17 == 5) begin
                expVal = (n >= DEPTH) ? words[n-DEPTH] : '0;
                applyStimulus(1'b0, 1'b1, $urandom, expVal, $sformatf("streamBStall%0d", k));
            end else begin
                n++;
                expVal = (n >= DEPTH) ? words[n-DEPTH] : '0;
                applyStimulus(1'b0, 1'b0, words[n-1], expVal, $sformatf("streamB%0d", k));
            end
        end

        // Reset wins over stall.
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h0, "rstDuringStall");
        applyStimulus(1'b0, 1'b1, 32'h8765_4321, 32'h0, "stallAfterRst");
        applyStimulus(1'b0, 1'b0, 32'h0000_0C0C, 32'h0, "postRst1");

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clock);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
